// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared FSM state type and sizing helpers for the chunked adder.
// Revision : 1.0
// ============================================================================
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : chunk_adder
// Purpose  : CHUNK-bit ripple of fac cells with carry taps for flag generation.
// Revision : 1.0
// ============================================================================
module chunk_adder #(
  parameter int CHUNK    = 4,
  parameter int TOP_LAST = CHUNK - 1
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_last,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ctop
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < CHUNK; g++) begin : g_fa
    fac u_fac (
      .i_a (i_a[g]),
      .i_b (i_b[g]),
      .i_c (w_c[g]),
      .o_s (o_sum[g]),
      .o_c (w_c[g+1])
    );
  end

  // A partial last chunk is zero-extended, so its real MSB sits at TOP_LAST.
  assign o_cout = i_last ? w_c[TOP_LAST+1] : w_c[CHUNK];
  assign o_ctop = i_last ? w_c[TOP_LAST]   : w_c[CHUNK-1];

endmodule
`default_nettype wire

// File: rtl/fac.sv
`default_nettype none
// ============================================================================
// Module   : fac
// Purpose  : Single-bit full-adder cell.
// Revision : 1.0
// ============================================================================
module fac (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule
`default_nettype wire

// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : seq_chunk_adder
// Purpose  : Multi-cycle add/sub, CHUNK bits per clock, valid/ready on both ends.
// Revision : 1.0
// ============================================================================
module seq_chunk_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK   = ceil_div(WIDTH, CHUNK);
  localparam int IW       = idx_width(NCHUNK);
  localparam int LAST_TOP = (WIDTH - 1) % CHUNK;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [31:0]      w_shift;
  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic [CHUNK-1:0] w_csum;
  logic             w_cout;
  logic             w_ctop;
  logic             w_last;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_sum_next;

  assign w_shift = 32'(r_idx) * 32'(CHUNK);
  assign w_ca    = CHUNK'(r_a >> w_shift);
  assign w_cb    = CHUNK'(r_b >> w_shift);
  assign w_last  = (r_idx == IW'(NCHUNK - 1));

  chunk_adder #(
    .CHUNK    (CHUNK),
    .TOP_LAST (LAST_TOP)
  ) u_chunk (
    .i_a    (w_ca),
    .i_b    (w_cb),
    .i_cin  (r_carry),
    .i_last (w_last),
    .o_sum  (w_csum),
    .o_cout (w_cout),
    .o_ctop (w_ctop)
  );

  assign w_mask     = WIDTH'({CHUNK{1'b1}}) << w_shift;
  assign w_sum_next = (r_sum & ~w_mask) | (WIDTH'(w_csum) << w_shift);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = RUN;
      RUN:     if (w_last)   w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction folds into addition of the inverted operand.
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= cin ^ sub;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_cout;
          if (w_last) begin
            r_cout <= w_cout;
            r_ovf  <= w_cout ^ w_ctop;
            r_zero <= (w_sum_next == '0);
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_chunk_adder
// Purpose  : Directed and randomized checks of seq_chunk_adder across parameter sets.
// Revision : 1.0
// ============================================================================
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  in_valid;
  logic [4:0]  out_ready;
  logic [16:0] a;
  logic [16:0] b;
  logic        cin;
  logic        sub;

  wire  [4:0]  in_ready_v;
  wire  [4:0]  out_valid_v;
  wire  [4:0]  cout_v;
  wire  [4:0]  ovf_v;
  wire  [4:0]  zero_v;
  wire  [16:0] s0, s1, s2;
  wire  [7:0]  s3;
  wire  [0:0]  s4;

  int checks = 0;
  int errors = 0;
  int WV[5]  = '{17, 17, 17, 8, 1};
  int NC[5]  = '{5, 1, 17, 3, 1};

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(17), .CHUNK(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_v[0]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_v[0]), .out_ready(out_ready[0]),
    .sum(s0), .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0]));
  seq_chunk_adder #(.WIDTH(17), .CHUNK(17)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_v[1]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_v[1]), .out_ready(out_ready[1]),
    .sum(s1), .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1]));
  seq_chunk_adder #(.WIDTH(17), .CHUNK(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready_v[2]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_v[2]), .out_ready(out_ready[2]),
    .sum(s2), .cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2]));
  seq_chunk_adder #(.WIDTH(8), .CHUNK(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready_v[3]),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub), .out_valid(out_valid_v[3]), .out_ready(out_ready[3]),
    .sum(s3), .cout(cout_v[3]), .ovf(ovf_v[3]), .zero(zero_v[3]));
  seq_chunk_adder #(.WIDTH(1), .CHUNK(1)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[4]), .in_ready(in_ready_v[4]),
    .a(a[0:0]), .b(b[0:0]), .cin(cin), .sub(sub), .out_valid(out_valid_v[4]), .out_ready(out_ready[4]),
    .sum(s4), .cout(cout_v[4]), .ovf(ovf_v[4]), .zero(zero_v[4]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] get_sum(input int k);
    case (k)
      0:       return s0;
      1:       return s1;
      2:       return s2;
      3:       return {9'd0, s3};
      default: return {16'd0, s4};
    endcase
  endfunction

  // Reference: plain integer arithmetic; overflow from the signed-range definition.
  task automatic model(input int w, input logic [16:0] ta, input logic [16:0] tb,
                       input logic tcin, input logic tsub,
                       output logic [16:0] es, output logic ec, output logic eo, output logic ez);
    longint m, ua, ube, ce, full, sa, sbe, ss, half;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(ta) & m;
    ube  = (tsub ? ~longint'(tb) : longint'(tb)) & m;
    ce   = longint'(tcin ^ tsub);
    full = ua + ube + ce;
    es   = 17'(full & m);
    ec   = ((full >> w) & 1) != 0;
    sa   = (ua  >= half) ? ua  - (m + 1) : ua;
    sbe  = (ube >= half) ? ube - (m + 1) : ube;
    ss   = sa + sbe + ce;
    eo   = (ss > half - 1) || (ss < -half);
    ez   = (es == 17'd0);
  endtask

  task automatic start_op(input int k, input logic [16:0] ta, input logic [16:0] tb,
                          input logic tcin, input logic tsub);
    a = ta; b = tb; cin = tcin; sub = tsub;
    check($sformatf("in_ready_idle[%0d]", k), 32'(in_ready_v[k]), 32'd1);
    in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    check($sformatf("in_ready_run[%0d]", k), 32'(in_ready_v[k]), 32'd0);
  endtask

  task automatic wait_done(input int k, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (out_valid_v[k] !== 1'b1 && lat < 100);
    check($sformatf("latency[%0d]", k), 32'(lat), 32'(NC[k]));
  endtask

  task automatic check_result(input int k, input logic [16:0] ta, input logic [16:0] tb,
                              input logic tcin, input logic tsub);
    logic [16:0] es;
    logic ec, eo, ez;
    model(WV[k], ta, tb, tcin, tsub, es, ec, eo, ez);
    check($sformatf("sum[%0d] a=%0h b=%0h c=%0b s=%0b", k, ta, tb, tcin, tsub), 32'(get_sum(k)), 32'(es));
    check($sformatf("cout[%0d]", k), 32'(cout_v[k]), 32'(ec));
    check($sformatf("ovf[%0d]", k), 32'(ovf_v[k]), 32'(eo));
    check($sformatf("zero[%0d]", k), 32'(zero_v[k]), 32'(ez));
  endtask

  task automatic finish_op(input int k);
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    check($sformatf("out_valid_drop[%0d]", k), 32'(out_valid_v[k]), 32'd0);
    check($sformatf("in_ready_back[%0d]", k), 32'(in_ready_v[k]), 32'd1);
  endtask

  task automatic run_op(input int k, input logic [16:0] ta, input logic [16:0] tb,
                        input logic tcin, input logic tsub);
    int lat;
    start_op(k, ta, tb, tcin, tsub);
    wait_done(k, lat);
    check_result(k, ta, tb, tcin, tsub);
    finish_op(k);
  endtask

  initial begin
    int lat;
    logic [16:0] held;
    rst_n = 1'b0; in_valid = '0; out_ready = '0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #23;
    check("rst_sum", 32'(s0), 32'd0);
    check("rst_flags", {27'd0, out_valid_v[0], cout_v[0], ovf_v[0], zero_v[0], 1'b0}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready_v[0]), 32'd1);

    // Directed cases on the default configuration.
    run_op(0, 17'd1, 17'd3, 1'b0, 1'b0);
    run_op(0, 17'h1FFFF, 17'd1, 1'b0, 1'b0);
    run_op(0, 17'd5, 17'd7, 1'b0, 1'b1);
    run_op(0, 17'd7, 17'd5, 1'b0, 1'b1);
    run_op(0, 17'd7, 17'd5, 1'b1, 1'b1);
    run_op(0, 17'h0FFFF, 17'd1, 1'b0, 1'b0);
    run_op(0, 17'h10000, 17'd1, 1'b0, 1'b1);
    check("ovf_neg_minus_pos", 32'(ovf_v[0]), 32'd1);

    // Backpressure: result held while the consumer stalls, new requests ignored.
    start_op(0, 17'd3, 17'd4, 1'b0, 1'b0);
    wait_done(0, lat);
    held = s0;
    check("bp_sum", 32'(held), 32'd7);
    in_valid[0] = 1'b1; a = 17'h12345; b = 17'h0ABCD;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid_v[0]), 32'd1);
      check("bp_hold", 32'(s0), 32'(held));
      check("bp_in_ready", 32'(in_ready_v[0]), 32'd0);
    end
    in_valid[0] = 1'b0;
    finish_op(0);

    // Reset during the third RUN cycle discards the partial result.
    start_op(0, 17'h0FFFF, 17'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_sum", 32'(s0), 32'd0);
    check("midrst_flags", {28'd0, out_valid_v[0], cout_v[0], ovf_v[0], zero_v[0]}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", 32'(in_ready_v[0]), 32'd1);
    check("midrst_no_valid", 32'(out_valid_v[0]), 32'd0);
    run_op(0, 17'd2, 17'd2, 1'b0, 1'b0);

    // Randomized sweep over all parameter sets.
    for (int k = 0; k < 5; k++) begin
      for (int n = 0; n < ((k == 0) ? 100 : 500); n++) begin
        logic [16:0] ra, rb;
        logic rc, rs;
        ra = 17'($urandom);
        rb = 17'($urandom);
        rc = 1'($urandom);
        rs = 1'($urandom);
        if (n < 4) begin
          ra = (n[0]) ? '1 : '0;
          rb = (n[1]) ? '1 : '0;
        end
        run_op(k, ra, rb, rc, rs);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
